// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register window, TX FIFO, 8N1 serialiser.
// Define MMIO_UART_PARITY_EN for 8E1 framing (adds an even-parity bit).
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MemWrite_EN,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef MMIO_UART_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd4;
  logic        par;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   div;
  logic [2:0]    state;
  logic [2:0]    bit_cnt;
  logic [15:0]   baud_cnt;
  logic [7:0]    shift;
  logic [7:0]    head;

  logic [1:0]  reg_sel;
  logic        wr_data;
  logic        wr_stat;
  logic        wr_div;
  logic        full;
  logic        empty;
  logic        baud_zero;
  logic        push;
  logic        pop;
  logic [15:0] reload;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{WriteData[31:16], MemAddr[1:0]};

  assign reg_sel   = MemAddr[3:2];
  assign Sel       = (MemAddr[31:4] == BASE_ADDR[31:4]);
  assign wr_data   = Sel & MemWrite_EN[0] & (reg_sel == 2'd0);
  assign wr_stat   = Sel & MemWrite_EN[0] & (reg_sel == 2'd1);
  assign wr_div    = Sel & (reg_sel == 2'd2);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign baud_zero = (baud_cnt == 16'd0);
  assign head      = mem[rd_ptr];
  assign reload    = (div == 16'd0) ? 16'd0 : div - 16'd1;

  // Fullness uses the pre-edge count, so a push racing a pop while full drops.
  assign push = wr_data & ~full;
  assign pop  = ~empty & ((state == S_IDLE) |
                          ((state == S_STOP) & baud_zero));

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = (state != S_IDLE);
    status[3]   = ovf;
    status[8:4] = 5'(count);
`ifdef MMIO_UART_PARITY_EN
    status[9]   = 1'b1;
`endif
  end

  always_comb begin
    ReadData = '0;
    if (Sel) begin
      case (reg_sel)
        2'd1:    ReadData = status;
        2'd2:    ReadData = {16'h0, div};
        default: ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      div    <= 16'(CLK_DIV);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (~push & pop) count <= count - CW'(1);
      if (wr_data & full)
        ovf <= 1'b1;
      else if (wr_stat & WriteData[3])
        ovf <= 1'b0;
      if (wr_div & MemWrite_EN[0]) div[7:0]  <= WriteData[7:0];
      if (wr_div & MemWrite_EN[1]) div[15:8] <= WriteData[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
      shift    <= 8'd0;
`ifdef MMIO_UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      // New divisor values are only picked up here, at a bit boundary.
      if (state != S_IDLE)
        baud_cnt <= baud_zero ? reload : baud_cnt - 16'd1;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            tx       <= 1'b0;
            shift    <= head;
            baud_cnt <= reload;
`ifdef MMIO_UART_PARITY_EN
            par      <= ^head;
`endif
          end
        end
        S_START: begin
          if (baud_zero) begin
            state   <= S_DATA;
            tx      <= shift[0];
            bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              state <= S_PAR;
              tx    <= par;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end
        end
`ifdef MMIO_UART_PARITY_EN
        S_PAR: begin
          if (baud_zero) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_zero) begin
            if (pop) begin
              state <= S_START;
              tx    <= 1'b0;
              shift <= head;
`ifdef MMIO_UART_PARITY_EN
              par   <= ^head;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter attached to the processor core's data-memory port (MemWrite_EN / MemAddr / WriteData / ReadData), alongside the data RAM.
- Decodes a small register window. Software writes bytes into a TX FIFO, and a bit-timing FSM serialises them onto a single output line.
- Gives programs running on the pipelined core a debug and console output.
- The top level muxes ReadData from this block or from dmem using the Sel output.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; must be 16-byte aligned.
- CLK_DIV, 868, reset value of the divisor register, in clk cycles per bit; 868 gives 100 MHz / 115200.
- FIFO_DEPTH, 8, number of TX FIFO entries; must be a power of 2, range 2..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite_EN  in  4  byte-lane write enables from the core.
- MemAddr  in  32  byte address from the core.
- WriteData  in  32  store data from the core.
- ReadData  out  32  register read data; combinational from MemAddr; 0 when not selected.
- Sel  out  1  combinational; 1 when MemAddr[31:4] == BASE_ADDR[31:4].
- tx  out  1  serial output, registered; idles high.

Behaviour:
- Address map (offset = MemAddr[3:0]; MemAddr[1:0] ignored):
  - 0x0 TXDATA: a write with Sel & MemWrite_EN[0] pushes WriteData[7:0]. Reads return 0.
  - 0x4 STATUS, read fields: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [8:4] fifo count, others 0.
  - 0x4 STATUS, write: a write with MemWrite_EN[0] and WriteData[3]=1 clears overflow. All other STATUS bits are read-only.
  - 0x8 DIV: 16-bit read/write. A write stores WriteData[15:0], but only for lanes enabled in MemWrite_EN[1:0]. Reads are zero-extended.
  - 0xC: reserved; reads 0, writes ignored.
- Reads are combinational, matching the core's single-cycle dmem read path. Reads have no side effects.
- Writes take effect at the rising edge of the cycle in which they are presented.
- Reset values:
  - tx=1, FIFO empty (count 0), overflow=0, DIV=CLK_DIV, FSM=IDLE, bit counter 0, baud counter 0.
  - ReadData and Sel are combinational and have no reset value.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - Push while full: data is dropped, overflow is set, and count is unchanged.
  - Fullness is judged on the pre-edge count. A push arriving in the same cycle as a pop while full is dropped.
  - Push and pop in the same cycle when not full: count is unchanged and both pointers advance.
- Bit timing:
  - Effective divisor D = (DIV==0) ? 1 : DIV.
  - The baud counter counts D-1 down to 0. Reaching 0 marks a bit boundary and reloads the counter.
  - A DIV write during a frame takes effect at the next reload. It never truncates the current bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START; tx=0 is registered at the same edge.
  - START: hold tx=0 for D cycles, then go to DATA with tx=shift[0].
  - DATA: shift LSB first, 8 bits of D cycles each, tracked by a 3-bit counter. After bit 7 go to STOP with tx=1.
  - STOP: hold tx=1 for D cycles. Then, if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- Latency:
  - A push accepted at edge k into an empty FIFO with the FSM in IDLE gives tx falling after edge k+1.
  - A frame is 10*D cycles (8N1).
- Reset asserted mid-frame: tx returns high immediately (asynchronous) and queued bytes are discarded.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP that transmits even parity (XOR of the 8 data bits) for D cycles.
  - Frame becomes 8E1, 11*D cycles.
  - STATUS[9] reads 1 to advertise parity.
- When undefined:
  - No PARITY state; frame is 8N1, 10*D cycles.
  - STATUS[9] reads 0.

Test Plan:
- Reset then read BASE+0x4 -> ReadData=32'h0000_0002 (empty); read BASE+0x8 -> 868; tx=1; Sel=0 for MemAddr=32'h0000_0100.
- Write DIV=4, then write TXDATA=8'hA5 -> tx low one cycle after the accept edge. Expected line sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); busy=1 during the frame and 0 after.
- Write 3 bytes 8'h01,8'h02,8'h03 back-to-back with DIV=2 -> three contiguous frames with no idle between the stop bit and the next start bit; total 60 cycles; count reads 2, 1 and 0 as frames begin.
- With DIV=100, write FIFO_DEPTH+2 bytes quickly -> STATUS full=1, overflow=1; writing STATUS with bit3=1 -> overflow=0; only the first FIFO_DEPTH+1 bytes appear on tx (one is popped immediately).
- With DIV=4, mid-frame (after bit 3) write DIV=8 -> remaining bits last 8 cycles; then assert reset mid-frame -> tx=1 asynchronously, count=0, DIV=868.
- With MMIO_UART_PARITY_EN defined, send 8'h07 with DIV=2 -> parity bit 1 before the stop bit, frame 22 cycles; send 8'h03 -> parity bit 0.
